// File: rtl/or1200_cl_dec_xor.sv
// Cache-line refill decryptor: XORs refill words with latched pads.
// Ports: clk/rst, refill/enc control, bus words in, data-cache words out.
module or1200_cl_dec_xor #(
  parameter int LINE_WORDS = 8,
  parameter int DW         = 32,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          secure_exec,
  input  logic          refill_start,
  input  logic          enc_done,
  input  logic [127:0]  enc_pad_1,
  input  logic [127:0]  enc_pad_2,
  input  logic [DW-1:0] bus_dat_i,
  input  logic          bus_ack_i,
  input  logic          dc_ready_i,
  output logic [DW-1:0] dc_dat_o,
  output logic          dc_valid_o,
  output logic          busy_o,
  output logic          line_done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PAD,
    STREAM,
    FLUSH
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);

  state_t          state_q;
  logic            mode_q;
  logic            pad_valid_q;
  logic [127:0]    pad1_q;
  logic [127:0]    pad2_q;
  logic [CW-1:0]   in_cnt_q;
  logic [CW-1:0]   out_cnt_q;
  logic [DW-1:0]   mem_q [LINE_WORDS];

  logic [255:0]    pads;
  logic [DW-1:0]   head;
  logic [DW-1:0]   slice;
  logic            busy;
  logic            empty;
  logic            valid;
  logic            push;
  logic            pop;

  assign pads  = {pad1_q, pad2_q};
  assign busy  = state_q != IDLE;
  // in_cnt/out_cnt double as write/read pointers: one line fills once.
  assign empty = in_cnt_q == out_cnt_q;
  assign valid = (state_q == STREAM) & ~empty
               & (pad_valid_q | ~mode_q);
  assign push  = bus_ack_i & busy & (in_cnt_q < FULL);
  assign pop   = valid & dc_ready_i;

  always_comb begin
    head  = '0;
    slice = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (out_cnt_q == CW'(i)) begin
        head  = mem_q[i];
        slice = pads[255-32*i -: 32];
      end
    end
  end

  assign dc_valid_o  = valid;
  assign dc_dat_o    = valid ? (head ^ (mode_q ? slice : '0)) : '0;
  assign busy_o      = busy;
  assign line_done_o = state_q == FLUSH;
  assign err_o       = (refill_start & busy)
                     | (bus_ack_i & (~busy | (in_cnt_q == FULL)));

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (in_cnt_q == CW'(i)) mem_q[i] <= bus_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      pad_valid_q <= 1'b0;
      pad1_q      <= '0;
      pad2_q      <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
    end else begin
      if (push) in_cnt_q <= in_cnt_q + 1'b1;
      if (pop) out_cnt_q <= out_cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (refill_start) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mode_q    <= secure_exec;
            if (!secure_exec) begin
              state_q <= STREAM;
            end else if (enc_done) begin
              pad1_q      <= enc_pad_1;
              pad2_q      <= enc_pad_2;
              pad_valid_q <= 1'b1;
              state_q     <= STREAM;
            end else begin
              state_q <= WAIT_PAD;
            end
          end
        end
        WAIT_PAD: begin
          if (enc_done) begin
            pad1_q      <= enc_pad_1;
            pad2_q      <= enc_pad_2;
            pad_valid_q <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (pop && out_cnt_q == LAST) state_q <= FLUSH;
        end
        FLUSH: begin
          pad_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/or1200_cl_dec_xor.md
Name: or1200_cl_dec_xor

Overview:
- Downstream consumer of the cache-line encryption engine.
- Latches the two 128-bit encryption pads when the engine signals done. Collects refill words from the bus interface during a secure data-cache line refill, and XORs each word with its pad slice to produce plaintext for the data cache.
- Buffers refill words that arrive before the pads are ready, or while the cache stalls. In non-secure refills it passes words through unmodified.

Parameters:
- LINE_WORDS, 8, words per cache line; legal range 1..8 (two 128-bit pads cover at most 8 words).
- DW, 32, data word width; fixed at 32.
- CW, 4, counter width; must satisfy 2^CW > LINE_WORDS.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- secure_exec  input  1  secure mode; sampled on refill_start to choose XOR mode (1) or bypass mode (0).
- refill_start  input  1  one-cycle pulse at the start of a data-cache line refill.
- enc_done  input  1  one-cycle pulse from the encryption engine; pads are valid in this cycle.
- enc_pad_1  input  128  pad for words 0..3.
- enc_pad_2  input  128  pad for words 4..7.
- bus_dat_i  input  DW  refill data word from the bus interface.
- bus_ack_i  input  1  refill word valid; there is no backpressure to the bus.
- dc_ready_i  input  1  data cache accepts a word this cycle.
- dc_dat_o  output  DW  plaintext word to the data cache.
- dc_valid_o  output  1  dc_dat_o is valid.
- busy_o  output  1  a line is in progress.
- line_done_o  output  1  one-cycle pulse after the last word is accepted.
- err_o  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - FSM goes to IDLE; all counters, FIFO pointers and pad_valid are cleared; the pad registers are zeroed.
  - dc_valid_o, busy_o, line_done_o, err_o are 0; dc_dat_o is 0.
  - Reset mid-line abandons the line; buffered words are discarded.
- FSM states: IDLE, WAIT_PAD, STREAM, FLUSH.
  - IDLE: on refill_start, clear in_cnt/out_cnt and latch mode=secure_exec. Go to STREAM if mode=0, else WAIT_PAD.
  - WAIT_PAD: on enc_done, latch enc_pad_1/enc_pad_2 into internal registers, set pad_valid, go to STREAM. Refill words keep entering the FIFO in this state.
  - STREAM: drain the FIFO. When the last word is accepted (dc_valid_o & dc_ready_i with out_cnt==LINE_WORDS-1), go to FLUSH.
  - FLUSH: one cycle; line_done_o=1, pad_valid cleared, then IDLE.
- enc_done in the same cycle as refill_start in XOR mode: pads are captured in that cycle and the FSM goes directly to STREAM.
- enc_done in IDLE, STREAM, FLUSH, or in bypass mode is ignored; the pad registers are unchanged.
- FIFO:
  - Depth LINE_WORDS, registered storage.
  - A write occurs when bus_ack_i=1 and busy_o=1 and in_cnt<LINE_WORDS; in_cnt then increments.
  - A word written at edge t is visible at the head from cycle t+1. Minimum latency is 1 cycle from bus_ack_i to dc_valid_o.
- Output:
  - dc_valid_o = (state==STREAM) & FIFO not empty.
  - dc_dat_o = head ^ pad slice in XOR mode; dc_dat_o = head in bypass mode; dc_dat_o = 0 when not valid.
  - Pad slice for word k: k<4 uses enc_pad_1[127-32k -: 32]; k>=4 uses enc_pad_2[127-32(k-4) -: 32]. k = out_cnt.
  - A pop occurs on dc_valid_o & dc_ready_i; out_cnt then increments.
  - Simultaneous push and pop in one cycle is supported; FIFO occupancy is unchanged.
- busy_o = 1 in WAIT_PAD, STREAM and FLUSH.
- err_o pulses, with no other effect, when:
  - refill_start arrives while busy_o=1; the pulse is ignored.
  - bus_ack_i arrives while in IDLE, or with in_cnt==LINE_WORDS; the word is dropped.

Test Plan:
- Secure refill, pad first: refill_start with secure_exec=1, then enc_done with enc_pad_1=128'h0123..cdef, then 8 acks of 32'hFFFFFFFF with dc_ready_i=1 -> dc_dat_o word0=32'hFEDCBA98, words match ~pad slices; line_done_o pulses once after word 7.
- Words before pad: all 8 acks arrive, enc_done arrives 5 cycles later -> dc_valid_o stays 0 until the cycle after enc_done, then 8 consecutive correct words; no err_o.
- Bypass: secure_exec=0, words 0..7 = 32'h10+k -> dc_dat_o = 32'h10+k unchanged; any enc_done is ignored.
- Backpressure: dc_ready_i toggles 1,0,0,1 throughout -> no words lost or duplicated, order preserved, out_cnt ends at 8.
- Violations: a 9th ack -> err_o=1 for one cycle, output unaffected. refill_start while busy -> err_o=1, line continues.
- Reset mid-line after 3 words delivered -> all outputs 0 next cycle. A new refill then delivers correct words from word 0.
